// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
// Groups the byte-write side, the status flags and the UART transmitter
// handshake of uart_tx_fifo into one bundle.
//   slave  modport : the FIFO itself (takes writes, drives status and tx byte)
//   master modport : the producer / transmitter side that talks to the FIFO
// Signals:
//   wr_en, wr_data  : byte write strobe and data
//   ovf_clr         : clears the sticky overflow flag
//   full, empty     : occupancy flags
//   level           : number of stored bytes (AW+1 bits)
//   overflow        : sticky "a write was dropped" flag
//   new_data        : byte request to the transmitter
//   tx_data         : byte presented to the transmitter
//   donetx          : transmitter frame-complete level
//   busy            : FIFO is feeding the transmitter (state SEND)
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          ovf_clr;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          new_data;
    logic [7:0]    tx_data;
    logic          donetx;
    logic          busy;

    modport slave (
        input  wr_en, wr_data, ovf_clr, donetx,
        output full, empty, level, overflow, new_data, tx_data, busy
    );

    modport master (
        output wr_en, wr_data, ovf_clr, donetx,
        input  full, empty, level, overflow, new_data, tx_data, busy
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte FIFO in front of a UART transmitter. Bytes are written through the
// bus interface, stored in a circular buffer and handed to the transmitter
// one at a time. A two-state FSM (IDLE/SEND) pops the head whenever the
// transmitter is idle, and pops the next byte on the rising edge of donetx
// so that frames can run back to back.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   bus : uart_tx_fifo_if.slave (write side, status flags, tx handshake)
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_full;
    logic          r_empty;
    logic          r_overflow;
    logic          r_donetx_d;
    logic          r_new_data;
    logic [7:0]    r_tx_data;
    logic          r_busy;
    state_t        r_state;

    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_done_edge;
    logic [AW:0]   w_level_nxt;

    // Handshake decode: accepted write, dropped write, donetx rising edge, pop.
    // The pop decision uses the registered empty flag, so a write in the same
    // cycle cannot be popped until the following cycle.
    assign w_push      = bus.wr_en & ~r_full;
    assign w_drop      = bus.wr_en &  r_full;
    assign w_done_edge = bus.donetx & ~r_donetx_d;
    assign w_pop       = ~r_empty & ((r_state == S_IDLE) | w_done_edge);

    // Next occupancy; a simultaneous push and pop leaves the level unchanged.
    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + (AW+1)'(1);
            2'b01:   w_level_nxt = r_level - (AW+1)'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Byte storage; contents are not cleared by reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    // Pointers, occupancy flags, sticky overflow and donetx delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_donetx_d <= 1'b0;
        end else begin
            r_donetx_d <= bus.donetx;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_level_nxt == (AW+1)'(0));
            // A dropped write wins over a clear in the same cycle.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Transmit FSM with registered new_data, tx_data and busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_new_data <= 1'b0;
            r_tx_data  <= 8'h00;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // donetx edges are ignored here; only occupancy matters.
                    if (!r_empty) begin
                        r_tx_data  <= r_mem[r_rd_ptr];
                        r_new_data <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_SEND;
                    end else begin
                        r_new_data <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (w_done_edge && !r_empty) begin
                        r_tx_data  <= r_mem[r_rd_ptr];
                        r_new_data <= 1'b1;
                    end else if (w_done_edge) begin
                        r_new_data <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_new_data <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.full     = r_full;
    assign bus.empty    = r_empty;
    assign bus.level    = r_level;
    assign bus.overflow = r_overflow;
    assign bus.new_data = r_new_data;
    assign bus.tx_data  = r_tx_data;
    assign bus.busy     = r_busy;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo. The bench plays both the byte
// producer and the UART transmitter. Every accepted byte is pushed to a
// scoreboard queue when written and popped/compared when the FIFO presents
// it on tx_data. Inputs change 1 time unit after the rising edge, outputs
// are sampled at the same point.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [7:0] sb_q[$];

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare presented byte against the scoreboard head.
    task automatic chk_tx(input string tag);
        logic [31:0] exp;
        exp = (sb_q.size() > 0) ? {24'h0, sb_q.pop_front()} : 32'hDEAD;
        chk({tag, "_tx"}, {24'h0, bus.tx_data}, exp);
        chk({tag, "_nd"}, {31'h0, bus.new_data}, 32'd1);
    endtask

    task automatic write_byte(input logic [7:0] b, input bit accepted);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        if (accepted) sb_q.push_back(b);
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // One transmitter frame completion: donetx high for 2 cycles.
    task automatic pulse_done(input string tag, input bit more);
        logic nd_after;
        logic [7:0] tx_after;
        bus.donetx = 1'b1;
        tick();
        if (more) begin
            chk_tx(tag);
        end else begin
            chk({tag, "_nd_end"},   {31'h0, bus.new_data}, 32'd0);
            chk({tag, "_busy_end"}, {31'h0, bus.busy},     32'd0);
        end
        nd_after = bus.new_data;
        tx_after = bus.tx_data;
        tick();
        chk({tag, "_hold_nd"}, {31'h0, bus.new_data}, {31'h0, nd_after});
        chk({tag, "_hold_tx"}, {24'h0, bus.tx_data},  {24'h0, tx_after});
        bus.donetx = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.ovf_clr = 1'b0;
        bus.donetx  = 1'b0;

        // Reset state
        do_reset();
        chk("rst_level", {{(31-AW){1'b0}}, bus.level}, 32'd0);
        chk("rst_empty", {31'h0, bus.empty},    32'd1);
        chk("rst_full",  {31'h0, bus.full},     32'd0);
        chk("rst_ovf",   {31'h0, bus.overflow}, 32'd0);
        chk("rst_nd",    {31'h0, bus.new_data}, 32'd0);
        chk("rst_tx",    {24'h0, bus.tx_data},  32'h00);
        chk("rst_busy",  {31'h0, bus.busy},     32'd0);

        // Single byte latency
        write_byte(8'hA5, 1'b1);
        chk("lat_level1", {{(31-AW){1'b0}}, bus.level}, 32'd1);
        chk("lat_nd0",    {31'h0, bus.new_data}, 32'd0);
        tick();
        chk_tx("lat");
        chk("lat_busy", {31'h0, bus.busy}, 32'd1);
        pulse_done("lat_end", 1'b0);

        // Back-to-back frames
        write_byte(8'h11, 1'b1);
        write_byte(8'h22, 1'b1);
        write_byte(8'h33, 1'b1);
        chk_tx("b2b_0");
        pulse_done("b2b_1", 1'b1);
        pulse_done("b2b_2", 1'b1);
        pulse_done("b2b_3", 1'b0);

        // Fill, overflow, clear, drain
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            write_byte(8'h40 + 8'(i), 1'b1);
            if (i == DEPTH - 1) begin
                chk("fill_level_m1", {{(31-AW){1'b0}}, bus.level}, DEPTH - 1);
                chk("fill_notfull",  {31'h0, bus.full}, 32'd0);
            end
        end
        chk("fill_full",  {31'h0, bus.full}, 32'd1);
        chk("fill_level", {{(31-AW){1'b0}}, bus.level}, DEPTH);
        chk_tx("fill_first");
        write_byte(8'hFF, 1'b0);
        chk("ovf_set",   {31'h0, bus.overflow}, 32'd1);
        chk("ovf_level", {{(31-AW){1'b0}}, bus.level}, DEPTH);
        bus.ovf_clr = 1'b1;
        write_byte(8'hFE, 1'b0);
        chk("ovf_prio", {31'h0, bus.overflow}, 32'd1);
        tick();
        bus.ovf_clr = 1'b0;
        chk("ovf_clr", {31'h0, bus.overflow}, 32'd0);
        pulse_done("drain_first", 1'b1);
        chk("drain_level", {{(31-AW){1'b0}}, bus.level}, DEPTH - 1);
        chk("drain_notfull", {31'h0, bus.full}, 32'd0);
        while (sb_q.size() > 0) pulse_done("drain", 1'b1);
        pulse_done("drain_end", 1'b0);
        chk("drain_empty", {31'h0, bus.empty}, 32'd1);

        // Write coincident with popping done_edge
        write_byte(8'h5A, 1'b1);
        write_byte(8'h6B, 1'b1);
        chk_tx("coin_0");
        chk("coin_lvl_pre", {{(31-AW){1'b0}}, bus.level}, 32'd1);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h7C;
        sb_q.push_back(8'h7C);
        bus.donetx  = 1'b1;
        tick();
        bus.wr_en   = 1'b0;
        chk("coin_lvl_post", {{(31-AW){1'b0}}, bus.level}, 32'd1);
        chk_tx("coin_1");
        tick();
        bus.donetx = 1'b0;
        tick();
        pulse_done("coin_2", 1'b1);
        pulse_done("coin_end", 1'b0);

        // Reset in the middle of SEND with bytes queued; writes during reset ignored
        for (int i = 0; i < 5; i++) write_byte(8'hC0 + 8'(i), 1'b1);
        chk("mid_level", {{(31-AW){1'b0}}, bus.level}, 32'd4);
        rst         = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hEE;
        tick();
        rst       = 1'b0;
        bus.wr_en = 1'b0;
        sb_q.delete();
        chk("mid_nd",    {31'h0, bus.new_data}, 32'd0);
        chk("mid_level0", {{(31-AW){1'b0}}, bus.level}, 32'd0);
        chk("mid_empty", {31'h0, bus.empty},    32'd1);
        chk("mid_ovf",   {31'h0, bus.overflow}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            bus.donetx = 1'b1;
            tick();
            tick();
            bus.donetx = 1'b0;
            tick();
            chk("mid_post_nd", {31'h0, bus.new_data}, 32'd0);
        end

        // donetx held high across reset release
        bus.donetx = 1'b1;
        do_reset();
        write_byte(8'h9C, 1'b1);
        write_byte(8'hAD, 1'b1);
        chk_tx("hold_0");
        tick();
        tick();
        chk("hold_tx_stable", {24'h0, bus.tx_data}, 32'h9C);
        chk("hold_level",     {{(31-AW){1'b0}}, bus.level}, 32'd1);
        bus.donetx = 1'b0;
        tick();
        pulse_done("hold_1", 1'b1);
        pulse_done("hold_end", 1'b0);

        chk("sb_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
